// File: rtl/dp_mem_arb.sv
// Round-robin sequencer sharing one dual-port memory between NUM_REQ requesters.
// Optional statistics counters are built only when DPMEM_ARB_STATS_EN is defined.
module dp_mem_arb #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      mem_enb,
  output logic                      mem_wr,
  output logic                      mem_rd,
  output logic [ADDR_W-1:0]         mem_w_addr,
  output logic [ADDR_W-1:0]         mem_r_addr,
  output logic [DATA_W-1:0]         mem_w_data,
  input  logic [DATA_W-1:0]         mem_r_data,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [15:0]               stat_wr_cnt,
  output logic [15:0]               stat_rd_cnt,
  output logic [15:0]               stat_stall_cnt
);

  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic [NUM_REQ-1:0] wr_cand;
  logic [NUM_REQ-1:0] rd_cand;
  assign wr_cand = req_valid & req_wr;
  assign rd_cand = req_valid & ~req_wr;

  logic [ID_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ID_W-1:0] rd_ptr_q, rd_ptr_d;
  logic            wr_hit, rd_hit, rd_go, collide;
  logic [ID_W-1:0] wr_idx, rd_idx;

  // Returns {found, index}; scanning far-to-near lets the nearest candidate win.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] cand,
                                            input logic [ID_W-1:0]    ptr);
    logic [ID_W:0] res;
    int            idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (cand[idx]) res = {1'b1, idx[ID_W-1:0]};
    end
    return res;
  endfunction

  function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    {wr_hit, wr_idx} = rr_pick(wr_cand, wr_ptr_q);
    {rd_hit, rd_idx} = rr_pick(rd_cand, rd_ptr_q);
    collide = wr_hit && rd_hit && (addr_arr[wr_idx] == addr_arr[rd_idx]);
    rd_go   = rd_hit && !collide;
  end

  always_comb begin
    req_ready = '0;
    if (rst) begin
      if (wr_hit) req_ready[wr_idx] = 1'b1;
      if (rd_go)  req_ready[rd_idx] = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_hit) wr_ptr_d = ptr_after(wr_idx);
    if (rd_go)  rd_ptr_d = ptr_after(rd_idx);
  end

  logic              mem_wr_q, mem_rd_q, mem_enb_q;
  logic [ADDR_W-1:0] mem_w_addr_q, mem_r_addr_q;
  logic [DATA_W-1:0] mem_w_data_q;
  logic [ID_W-1:0]   rd_id_q;
  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_id_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_wr_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_enb_q    <= 1'b0;
      mem_w_addr_q <= '0;
      mem_r_addr_q <= '0;
      mem_w_data_q <= '0;
      rd_id_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_wr_q  <= wr_hit;
      mem_rd_q  <= rd_go;
      mem_enb_q <= wr_hit || rd_go;
      if (wr_hit) begin
        mem_w_addr_q <= addr_arr[wr_idx];
        mem_w_data_q <= wdata_arr[wr_idx];
      end
      if (rd_go) begin
        mem_r_addr_q <= addr_arr[rd_idx];
        rd_id_q      <= rd_idx;
      end
      // Memory data arrives the cycle after mem_rd, so the response tag follows one stage later.
      rsp_valid_q <= mem_rd_q;
      if (mem_rd_q) rsp_id_q <= rd_id_q;
    end
  end

  assign mem_wr     = mem_wr_q;
  assign mem_rd     = mem_rd_q;
  assign mem_enb    = mem_enb_q;
  assign mem_w_addr = mem_w_addr_q;
  assign mem_r_addr = mem_r_addr_q;
  assign mem_w_data = mem_w_data_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = mem_r_data;

`ifdef DPMEM_ARB_STATS_EN
  logic [15:0] stat_wr_q, stat_rd_q, stat_stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_wr_q    <= '0;
      stat_rd_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      if (wr_hit && stat_wr_q != 16'hFFFF)     stat_wr_q    <= stat_wr_q + 1'b1;
      if (rd_go && stat_rd_q != 16'hFFFF)      stat_rd_q    <= stat_rd_q + 1'b1;
      if (collide && stat_stall_q != 16'hFFFF) stat_stall_q <= stat_stall_q + 1'b1;
    end
  end

  assign stat_wr_cnt    = stat_wr_q;
  assign stat_rd_cnt    = stat_rd_q;
  assign stat_stall_cnt = stat_stall_q;
`else
  assign stat_wr_cnt    = '0;
  assign stat_rd_cnt    = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dp_mem_arb.sv
// Directed bench for dp_mem_arb (default parameters: 4 requesters, 4-bit addr, 8-bit data).
module tb_dp_mem_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_wr;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_ready;
  logic        mem_enb, mem_wr, mem_rd;
  logic [3:0]  mem_w_addr, mem_r_addr;
  logic [7:0]  mem_w_data, mem_r_data;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic [15:0] stat_wr_cnt, stat_rd_cnt, stat_stall_cnt;

  int checks   = 0;
  int failures = 0;

  dp_mem_arb #(.NUM_REQ(4), .ADDR_W(4), .DATA_W(8), .ID_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .mem_enb        (mem_enb),
    .mem_wr         (mem_wr),
    .mem_rd         (mem_rd),
    .mem_w_addr     (mem_w_addr),
    .mem_r_addr     (mem_r_addr),
    .mem_w_data     (mem_w_data),
    .mem_r_data     (mem_r_data),
    .rsp_valid      (rsp_valid),
    .rsp_id         (rsp_id),
    .rsp_data       (rsp_data),
    .stat_wr_cnt    (stat_wr_cnt),
    .stat_rd_cnt    (stat_rd_cnt),
    .stat_stall_cnt (stat_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DPMEM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [3:0] a, input logic [7:0] d);
    req_valid[i]         = v;
    req_wr[i]            = w;
    req_addr[i*4 +: 4]   = a;
    req_wdata[i*8 +: 8]  = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_id;
    rst        = 1'b0;
    mem_r_data = 8'h00;
    clear_reqs();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 4'(i), 8'h00);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 0);
    check("rst_enb", 32'(mem_enb), 0);
    check("rst_wr_rd", 32'({mem_wr, mem_rd}), 0);
    check("rst_addrs", 32'({mem_w_addr, mem_r_addr}), 0);
    check("rst_rsp", 32'({rsp_valid, rsp_id}), 0);
    check("rst_stats", 32'(stat_wr_cnt | stat_rd_cnt | stat_stall_cnt), 0);
    clear_reqs();
    rst = 1'b1;
    step();

    // Single write by req 0: addr 3, data A5
    set_req(0, 1'b1, 1'b1, 4'd3, 8'hA5);
    #1;
    check("wr0_ready", 32'(req_ready), 'b0001);
    step();
    clear_reqs();
    #1;
    check("wr0_mem_wr", 32'({mem_wr, mem_enb, mem_rd}), 'b110);
    check("wr0_w_addr", 32'(mem_w_addr), 3);
    check("wr0_w_data", 32'(mem_w_data), 'hA5);
    check("wr0_ready_drop", 32'(req_ready), 0);
    step();
    check("idle_strobes", 32'({mem_wr, mem_enb, mem_rd}), 0);
    check("idle_hold_addr", 32'(mem_w_addr), 3);
    check("idle_hold_data", 32'(mem_w_data), 'hA5);

    // Read by req 2 of addr 3; rptr 0 -> 3 after grant
    set_req(2, 1'b1, 1'b0, 4'd3, 8'h00);
    mem_r_data = 8'hA5;
    #1;
    check("rd2_ready", 32'(req_ready), 'b0100);
    step();
    clear_reqs();
    #1;
    check("rd2_mem_rd", 32'({mem_rd, mem_enb, mem_wr}), 'b110);
    check("rd2_r_addr", 32'(mem_r_addr), 3);
    check("rd2_no_rsp_yet", 32'(rsp_valid), 0);
    step();
    check("rd2_rsp_valid", 32'(rsp_valid), 1);
    check("rd2_rsp_id", 32'(rsp_id), 2);
    check("rd2_rsp_data", 32'(rsp_data), 'hA5);
    step();
    check("rd2_rsp_one_cycle", 32'(rsp_valid), 0);

    // All four write continuously; wptr is 1, so grants go 1,2,3,0,1,2
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 4'(i), 8'(8'h10 + i));
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_id = (1 + k) % 4;
      check($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(1 << exp_id));
      step();
      check($sformatf("rr_w_addr_%0d", k), 32'(mem_w_addr), 32'(exp_id));
      check($sformatf("rr_w_data_%0d", k), 32'(mem_w_data), 32'(16 + exp_id));
    end
    clear_reqs();
    #1;

    // Collision: req1 writes addr 5, req3 reads addr 5 (wptr=3, rptr=3)
    set_req(1, 1'b1, 1'b1, 4'd5, 8'h5A);
    set_req(3, 1'b1, 1'b0, 4'd5, 8'h00);
    #1;
    check("col_ready_N", 32'(req_ready), 'b0010);
    step();
    set_req(1, 1'b0, 1'b0, 4'd0, 8'h00);
    #1;
    check("col_ready_N1", 32'(req_ready), 'b1000);
    check("col_mem_wr", 32'({mem_wr, mem_rd}), 'b10);
    check("col_w_addr", 32'(mem_w_addr), 5);
    step();
    clear_reqs();
    mem_r_data = 8'h5A;
    #1;
    check("col_mem_rd", 32'({mem_wr, mem_rd}), 'b01);
    check("col_r_addr", 32'(mem_r_addr), 5);
    check("col_no_rsp_N2", 32'(rsp_valid), 0);
    step();
    check("col_rsp_valid_N3", 32'(rsp_valid), 1);
    check("col_rsp_id", 32'(rsp_id), 3);
    check("col_rsp_data", 32'(rsp_data), 'h5A);
    check("stat_stall", 32'(stat_stall_cnt), STATS ? 1 : 0);
    check("stat_wr", 32'(stat_wr_cnt), STATS ? 8 : 0);
    check("stat_rd", 32'(stat_rd_cnt), STATS ? 2 : 0);

    // Simultaneous write (req0 addr 2) and read (req1 addr 7); wptr=2, rptr=0
    set_req(0, 1'b1, 1'b1, 4'd2, 8'hC3);
    set_req(1, 1'b1, 1'b0, 4'd7, 8'h00);
    #1;
    check("dual_ready", 32'(req_ready), 'b0011);
    step();
    clear_reqs();
    #1;
    check("dual_strobes", 32'({mem_wr, mem_rd, mem_enb}), 'b111);
    check("dual_addrs", 32'({mem_w_addr, mem_r_addr}), 'h27);
    check("dual_w_data", 32'(mem_w_data), 'hC3);
    step();
    step();

    // Reset one cycle after a read handshake by req2 (rptr=2 -> 3)
    set_req(2, 1'b1, 1'b0, 4'd4, 8'h00);
    #1;
    check("mid_rd_ready", 32'(req_ready), 'b0100);
    step();
    clear_reqs();
    #1;
    check("mid_rd_issued", 32'(mem_rd), 1);
    rst = 1'b0;
    #1;
    check("mid_rst_strobes", 32'({mem_wr, mem_rd, mem_enb}), 0);
    check("mid_rst_addrs", 32'({mem_w_addr, mem_r_addr, mem_w_data}), 0);
    check("mid_rst_rsp", 32'({rsp_valid, rsp_id}), 0);
    check("mid_rst_stats", 32'(stat_wr_cnt | stat_rd_cnt | stat_stall_cnt), 0);
    step();
    check("mid_rst_no_rsp_a", 32'(rsp_valid), 0);
    rst = 1'b1;
    step();
    check("mid_rst_no_rsp_b", 32'(rsp_valid), 0);
    step();
    check("mid_rst_no_rsp_c", 32'(rsp_valid), 0);

    // Pointers back to 0: old wptr=1 would pick 3, old rptr=3 would pick 3
    set_req(0, 1'b1, 1'b1, 4'd1, 8'h11);
    set_req(3, 1'b1, 1'b1, 4'd2, 8'h22);
    #1;
    check("post_rst_wptr", 32'(req_ready), 'b0001);
    step();
    clear_reqs();
    set_req(0, 1'b1, 1'b0, 4'd8, 8'h00);
    set_req(3, 1'b1, 1'b0, 4'd9, 8'h00);
    #1;
    check("post_rst_rptr", 32'(req_ready), 'b0001);
    step();
    clear_reqs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
